uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Memory-mapped UART transmit channel, a slave on the core's MEM-stage memory map (uart slave port).
//  CPU stores push bytes into a TX FIFO; a baud-timed serializer drains the FIFO onto the tx pin.
//  A status register lets software poll busy/full/empty/overflow before storing.
//  Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// PARAMETERS
//  DATA_WIDTH    32   bus data width; only [7:0] is used for TX data
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200); must be >= 2
//  FIFO_DEPTH    8    TX FIFO entries; power of two, >= 2
// PORTS
//  i_clk      in   1           system clock
//  i_rst_n    in   1           asynchronous active-low reset
//  i_wd       in   DATA_WIDTH  store data from the memory map
//  i_address  in   32          byte address from the memory map; decode on i_address[3:2]
//  i_we       in   1           store strobe (slave selected and MemWrite)
//  i_re       in   1           load strobe (slave selected and MemRead)
//  o_rd       out  DATA_WIDTH  load data, combinational from i_address
//  o_tx       out  1           serial output, idle high
// BEHAVIOUR
//  Register map (i_address[3:2]): 0 = TXDATA (write-only, reads 0); 1 = STATUS (read-only); 2,3 read 0, writes ignored.
//  STATUS: [0] busy (state != IDLE); [1] full (count == FIFO_DEPTH); [2] empty (count == 0);
//   [3] overflow (sticky); [15:8] count; all other bits 0.
//  Reset: o_tx=1, state IDLE, FIFO pointers/count=0, overflow=0, baud and bit counters=0; STATUS reads 0x4.
//  Push: i_we && TXDATA && !full at a rising edge -> i_wd[7:0] written at wr_ptr, wr_ptr++ (wraps mod FIFO_DEPTH).
//  Push while full -> byte dropped, overflow<=1. full is evaluated before any same-cycle pop, so a write to a
//   full FIFO is dropped even if a pop occurs on the same edge.
//  Overflow clear: i_re && STATUS at a rising edge -> overflow<=0; o_rd still returns the pre-clear value that cycle.
//   If a dropped push and the clearing read coincide, set wins.
//  Simultaneous push and pop (not full): count unchanged, both pointers advance.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: o_tx=1; if !empty then pop into shift reg, rd_ptr++, baud_cnt=0, go START.
//   START: o_tx=0 for CLKS_PER_BIT cycles.
//   DATA: o_tx=shift[0], shift right each bit time; bit_cnt 0..7; after the 8th bit go PARITY or STOP.
//   STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
//  baud_cnt counts 0..CLKS_PER_BIT-1; the bit ends on the edge where baud_cnt==CLKS_PER_BIT-1.
//  o_tx is registered (glitch-free).
//  Latency: push captured at edge N into empty FIFO while IDLE -> pop at edge N+1 -> o_tx low from edge N+1.
//   Back-to-back frames have exactly 1 idle-high cycle between stop bit and next start bit.
//  Reset mid-frame: o_tx returns to 1 immediately (async); queued bytes are discarded.
//  i_re has no side effect except the overflow clear; i_we to non-TXDATA addresses has no effect.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA; o_tx = ^data (even parity) for CLKS_PER_BIT cycles;
//   frame is 11 bits.
//  Not defined: no PARITY state; frame is 10 bits; DATA goes directly to STOP.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=8 unless stated)
//  1 Reset -> o_tx=1; read STATUS -> 0x0000_0004; read addr 0x8 -> 0.
//  2 Write TXDATA=0x55 -> o_tx: 0 x4 cycles, then 1,0,1,0,1,0,1,0 x4 each, then 1 x4;
//    busy=1 during the frame, STATUS=0x4 after the frame.
//  3 Ten consecutive TXDATA writes 0x00..0x09 -> 0x00 popped immediately; 0x01..0x08 fill the FIFO;
//    0x09 dropped; STATUS=0x0000_080B. Serial output is 0x00..0x08 in order.
//  4 Read STATUS after test 3 -> returns overflow=1; next STATUS read -> bit3=0.
//  5 UART_TX_PARITY_EN, write 0x07 -> 8 data bits followed by parity bit 1, then stop; frame = 44 cycles.
//  6 Write 0xA5 plus 3 queued bytes; assert i_rst_n=0 mid DATA -> o_tx=1 at once; after release
//    STATUS=0x4 and o_tx stays 1 indefinitely.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmit channel.
// Software stores bytes into a TX FIFO. A baud-timed serializer drains the FIFO
// onto o_tx using 1 start bit, 8 data bits (LSB first), an optional parity bit
// and 1 stop bit. STATUS reports busy/full/empty/overflow and the FIFO count.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after the
// data bits, giving an 11-bit frame. Without it the frame is 10 bits.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_wd,
  input  logic [31:0]           i_address,
  input  logic                  i_we,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_rd,
  output logic                  o_tx
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO  = BAUD_W'(0);
  localparam logic [1:0]        REG_TXDATA = 2'd0;
  localparam logic [1:0]        REG_STATUS = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Even parity of one data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;

  // Serializer state
  state_t           state_r;
  state_t           state_next_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [BAUD_W-1:0] baud_next_s;
  logic [2:0]       bit_cnt_r;
  logic [2:0]       bit_next_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_next_s;
  logic             tx_r;
  logic             tx_next_s;
`ifdef UART_TX_PARITY_EN
  logic             parity_r;
  logic             parity_next_s;
`endif

  // Bus decode and status
  logic [1:0]            reg_sel_s;
  logic                  txdata_wr_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  pop_s;
  logic                  clr_ovf_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  busy_s;
  logic                  bit_end_s;
  logic [DATA_WIDTH-1:0] status_s;
  logic [DATA_WIDTH-1:0] rd_s;
  logic                  unused_s;

  // Only the low data byte and address bits [3:2] carry meaning on this slave.
  assign unused_s = ^{i_wd[DATA_WIDTH-1:8], i_address[31:4], i_address[1:0]};

  // Decode the bus access; full is sampled before any same-edge pop, so a store to a full FIFO is dropped.
  always_comb begin
    reg_sel_s   = i_address[3:2];
    full_s      = (count_r == CNT_FULL);
    empty_s     = (count_r == CNT_ZERO);
    txdata_wr_s = i_we && (reg_sel_s == REG_TXDATA);
    push_s      = txdata_wr_s && !full_s;
    drop_s      = txdata_wr_s && full_s;
    clr_ovf_s   = i_re && (reg_sel_s == REG_STATUS);
  end

  // FIFO pointers, storage, occupancy count and the sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= i_wd[7:0];
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A dropped store outranks a coincident clearing read.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Serializer state register; o_tx is registered so the pin never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_next_s;
      bit_cnt_r  <= bit_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_next_s;
`endif
    end
  end

  // Next-state logic: pop from IDLE, then step through the frame one bit time at a time.
  always_comb begin
    state_next_s  = state_r;
    baud_next_s   = baud_cnt_r;
    bit_next_s    = bit_cnt_r;
    shift_next_s  = shift_r;
    pop_s         = 1'b0;
    bit_end_s     = (baud_cnt_r == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
    parity_next_s = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s         = 1'b1;
          shift_next_s  = fifo_mem_r[rd_ptr_r];
          baud_next_s   = BAUD_ZERO;
          state_next_s  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_next_s = even_parity(fifo_mem_r[rd_ptr_r]);
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          bit_next_s   = 3'd0;
          state_next_s = ST_DATA;
        end else begin
          baud_next_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            bit_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            bit_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_cnt_r + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = ST_STOP;
        end else begin
          baud_next_s = baud_cnt_r + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = ST_IDLE;
        end else begin
          baud_next_s = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        baud_next_s  = BAUD_ZERO;
        bit_next_s   = 3'd0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: the pin level follows the state being entered so o_tx changes on the same edge.
  always_comb begin
    busy_s = (state_r != ST_IDLE);
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next_s = parity_next_s;
`endif
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // STATUS word and the combinational load-data mux.
  always_comb begin
    status_s       = {DATA_WIDTH{1'b0}};
    status_s[0]    = busy_s;
    status_s[1]    = full_s;
    status_s[2]    = empty_s;
    status_s[3]    = overflow_r;
    status_s[15:8] = 8'(count_r);
    case (reg_sel_s)
      REG_STATUS: rd_s = status_s;
      default:    rd_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign o_rd = rd_s;
  assign o_tx = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A frame-level reference model (a byte
// queue plus "serializer busy until edge N") predicts STATUS reads and serial
// frames; two monitors decode the DUT outputs and compare against queues.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] wd = '0;
  logic [31:0]   address = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [DW-1:0] rd;
  logic          tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wd(wd), .i_address(address),
    .i_we(we), .i_re(re), .o_rd(rd), .o_tx(tx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] b; int c; } frame_t;
  logic [7:0]  q_m[$];
  bit          active_m = 1'b0;
  int          end_m = 0;
  bit          ovf_m = 1'b0;
  frame_t      exp_tx_q[$];
  logic [31:0] exp_rd_q[$];

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = active_m;
    s[1] = (q_m.size() == DEPTH);
    s[2] = (q_m.size() == 0);
    s[3] = ovf_m;
    s[15:8] = 8'(q_m.size());
    return s;
  endfunction

  // Apply current inputs to the model for the coming edge, then advance one clock.
  task automatic tick();
    int k;
    bit full_now;
    bit drop;
    frame_t f;
    k = cyc + 1;
    full_now = (q_m.size() == DEPTH);
    if (re) exp_rd_q.push_back((address[3:2] == 2'd1) ? model_status() : 32'h0);
    if (active_m && k == end_m) begin
      active_m = 1'b0;
    end else if (!active_m && q_m.size() > 0) begin
      f.b = q_m.pop_front();
      f.c = k;
      exp_tx_q.push_back(f);
      active_m = 1'b1;
      end_m = k + FRAME * CPB;
    end
    drop = 1'b0;
    if (we && address[3:2] == 2'd0) begin
      if (full_now) drop = 1'b1;
      else q_m.push_back(wd[7:0]);
    end
    if (drop) ovf_m = 1'b1;
    else if (re && address[3:2] == 2'd1) ovf_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    we = 1'b0; re = 1'b0; wd = '0; address = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [7:0] d);
    we = 1'b1; re = 1'b0; address = a; wd = {$urandom(), d} ;
    wd[7:0] = d;
    tick();
    set_idle();
  endtask

  task automatic read_reg(input logic [31:0] a);
    we = 1'b0; re = 1'b1; address = a;
    tick();
    set_idle();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    set_idle();
    while ((q_m.size() > 0 || active_m || exp_tx_q.size() > 0) && guard < 20000) begin
      tick();
      guard++;
    end
    if (guard >= 20000) flag("drain_timeout");
    idle(2);
  endtask

  task automatic model_reset();
    q_m.delete();
    exp_tx_q.delete();
    exp_rd_q.delete();
    active_m = 1'b0;
    ovf_m = 1'b0;
  endtask

  // ---------------- load-data monitor ----------------
  initial begin : rd_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && re) begin
        if (exp_rd_q.size() == 0) flag("rd_no_expectation");
        else begin
          e = exp_rd_q.pop_front();
          check("rd_data", rd, e);
        end
      end
    end
  end

  // ---------------- serial monitor ----------------
  initial begin : tx_monitor
    int       sc;
    bit       abort;
    bit       stable;
    logic     bitv;
    logic     stopv;
    logic     parv;
    logic [7:0] d;
    frame_t   e;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        sc = cyc; abort = 1'b0; stable = 1'b1; d = 8'h00;
        stopv = 1'b0; parv = 1'b0; bitv = 1'b0;
        for (int bi = 0; bi < FRAME; bi++) begin
          for (int j = 0; j < CPB; j++) begin
            if (!(bi == 0 && j == 0)) begin
              @(negedge clk);
              if (!rst_n) abort = 1'b1;
            end
            if (abort) break;
            if (j == 0) bitv = tx;
            else if (tx !== bitv) stable = 1'b0;
          end
          if (abort) break;
          if (bi >= 1 && bi <= 8) d[bi-1] = bitv;
          else if (bi == FRAME - 1) stopv = bitv;
          else if (bi == 9) parv = bitv;
        end
        if (!abort) begin
          check("bit_stable", {31'h0, stable}, 32'h1);
          check("stop_bit", {31'h0, stopv}, 32'h1);
          if (exp_tx_q.size() == 0) flag("frame_unexpected");
          else begin
            e = exp_tx_q.pop_front();
            check("frame_data", {24'h0, d}, {24'h0, e.b});
            check("frame_start_cycle", sc, e.c);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", {31'h0, parv}, {31'h0, ^e.b});
`endif
          end
          @(negedge clk);
          if (rst_n) check("idle_gap_high", {31'h0, tx}, 32'h1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int density [4] = '{3, 35, 8, 60};
    int r;
    logic [31:0] a;
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("tx_in_reset", {31'h0, tx}, 32'h1);
    rst_n = 1'b1;
    idle(2);
    check("tx_after_reset", {31'h0, tx}, 32'h1);
    read_reg(32'h0000_0004);
    read_reg(32'h0000_0008);
    read_reg(32'h0000_0000);
    read_reg(32'h0000_000C);

    // Single frame 0x55
    write_reg(32'h0000_0000, 8'h55);
    idle(5);
    read_reg(32'h0000_0004);
    drain();
    read_reg(32'h0000_0004);

    // Ten back-to-back stores: fill, overflow, then the sticky flag clears on read
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; re = 1'b0; address = 32'h0; wd = 32'(i);
      tick();
    end
    set_idle();
    read_reg(32'h0000_0004);
    read_reg(32'h0000_0004);
    // Stores to non-TXDATA registers have no effect
    write_reg(32'h0000_0008, 8'hEE);
    write_reg(32'h0000_0004, 8'hEE);
    read_reg(32'h0000_0004);
    drain();
    read_reg(32'h0000_0004);

    // Randomized traffic with varying store density
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 700; n++) begin
        r = $urandom_range(0, 99);
        a = $urandom();
        a[3:2] = 2'($urandom_range(0, 3));
        set_idle();
        if (r < density[p]) begin
          we = 1'b1; address = a; address[3:2] = 2'd0; wd = $urandom();
        end else if (r < density[p] + 5) begin
          we = 1'b1; address = a; wd = $urandom();
        end else if (r < density[p] + 20) begin
          re = 1'b1; address = a;
        end
        tick();
      end
      set_idle();
      read_reg(32'h0000_0004);
    end
    drain();
    read_reg(32'h0000_0004);

    // Reset in the middle of a data bit with bytes still queued
    write_reg(32'h0000_0000, 8'hA5);
    write_reg(32'h0000_0000, 8'h11);
    write_reg(32'h0000_0000, 8'h22);
    write_reg(32'h0000_0000, 8'h33);
    idle(12);
    #2 rst_n = 1'b0;
    #1;
    check("tx_async_reset", {31'h0, tx}, 32'h1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    read_reg(32'h0000_0004);
    for (int n = 0; n < 20; n++) begin
      idle(10);
      check("tx_idle_after_reset", {31'h0, tx}, 32'h1);
    end
    read_reg(32'h0000_0004);
    if (exp_tx_q.size() != 0) flag("frames_outstanding");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
